// File: rtl/tick_generator.sv
// tick_generator: shared prescaler feeding NUM_CH runtime-programmable dividers,
// each emitting a one-cycle tick and a 50 % square wave used as clock enables.
module tick_generator #(
  parameter int CLK_HZ      = 100_000_000,
  parameter int BASE_HZ     = 1000,
  parameter int NUM_CH      = 4,
  parameter int DIV_W       = 16,
  parameter int DEFAULT_DIV = 1000,
  localparam int CW         = NUM_CH > 1 ? $clog2(NUM_CH) : 1
) (
  input  logic              clk,
  input  logic              reset_sync,
  input  logic              run,
  input  logic              clear,
  input  logic              cfg_we,
  input  logic [CW-1:0]     cfg_ch,
  input  logic [DIV_W-1:0]  cfg_div,
  output logic              cfg_err,
  output logic              base_tick,
  output logic [NUM_CH-1:0] tick,
  output logic [NUM_CH-1:0] square
);
  localparam int PRESCALE = CLK_HZ / BASE_HZ;
  localparam int PW = $clog2(PRESCALE);

  if (CLK_HZ % BASE_HZ != 0 || PRESCALE < 2) begin : g_bad_prescale
    $error("tick_generator: CLK_HZ/BASE_HZ must be an integer >= 2");
  end
  if (DEFAULT_DIV < 1 || DEFAULT_DIV > (1 << DIV_W) - 1) begin : g_bad_div
    $error("tick_generator: DEFAULT_DIV out of range");
  end
  if (NUM_CH < 1) begin : g_bad_ch
    $error("tick_generator: NUM_CH must be >= 1");
  end

  logic [PW-1:0]     r_pre_cnt;
  logic              r_base_tick, r_cfg_err;
  logic [NUM_CH-1:0] r_tick, r_square, r_pend_v, w_wrap;
  logic [DIV_W-1:0]  r_cnt [NUM_CH];
  logic [DIV_W-1:0]  r_div_act [NUM_CH];
  logic [DIV_W-1:0]  r_div_pend [NUM_CH];
  logic              w_wr_ok, w_pre_wrap;

  always_comb begin
    w_wr_ok = cfg_we && 32'(cfg_ch) < NUM_CH && cfg_div != '0;
    w_pre_wrap = r_pre_cnt == PW'(PRESCALE - 1);
    for (int i = 0; i < NUM_CH; i++)
      w_wrap[i] = run && r_base_tick && r_cnt[i] == r_div_act[i] - DIV_W'(1);
  end

  always_ff @(posedge clk or posedge reset_sync) begin
    if (reset_sync) begin
      r_pre_cnt   <= '0;
      r_base_tick <= 1'b0;
      r_cfg_err   <= 1'b0;
      r_tick      <= '0;
      r_square    <= '0;
      r_pend_v    <= '0;
      for (int i = 0; i < NUM_CH; i++) begin
        r_cnt[i]      <= '0;
        r_div_act[i]  <= DIV_W'(DEFAULT_DIV);
        r_div_pend[i] <= '0;
      end
    end else begin
      r_cfg_err <= cfg_we && !w_wr_ok;
      if (clear) begin
        r_pre_cnt   <= '0;
        r_base_tick <= 1'b0;
        r_tick      <= '0;
        r_square    <= '0;
        r_pend_v    <= '0;
        for (int i = 0; i < NUM_CH; i++) begin
          r_cnt[i] <= '0;
          if (r_pend_v[i]) r_div_act[i] <= r_div_pend[i];
        end
      end else begin
        r_base_tick <= run && w_pre_wrap;
        if (run) r_pre_cnt <= w_pre_wrap ? '0 : r_pre_cnt + PW'(1);
        r_tick   <= w_wrap;
        r_square <= r_square ^ w_wrap;
        // pending divisors only swap in at a wrap so no period is ever cut short
        for (int i = 0; i < NUM_CH; i++)
          if (run && r_base_tick) begin
            r_cnt[i] <= w_wrap[i] ? '0 : r_cnt[i] + DIV_W'(1);
            if (w_wrap[i] && r_pend_v[i]) begin
              r_div_act[i] <= r_div_pend[i];
              r_pend_v[i]  <= 1'b0;
            end
          end
      end
      if (w_wr_ok) begin
        r_div_pend[cfg_ch] <= cfg_div;
        r_pend_v[cfg_ch]   <= 1'b1;
      end
    end
  end

  assign cfg_err   = r_cfg_err;
  assign base_tick = r_base_tick;
  assign tick      = r_tick;
  assign square    = r_square;
endmodule

// File: tb/tb_tick_generator.sv
// tb_tick_generator: directed vectors for tick_generator with PRESCALE=5 and default divisor 3.
module tb_tick_generator;
  logic       clk = 0, reset_sync = 1, run = 1, clear = 0, cfg_we = 0;
  logic [0:0] cfg_ch = 0;
  logic [1:0] ch3 = 0;
  logic [3:0] cfg_div = 0;
  logic       cfg_err, base_tick, err3, base3;
  logic [1:0] tick, square;
  logic [2:0] tick3, sq3;
  int total = 0, bad = 0, e = 0;

  typedef struct {
    int rst, e, run, clr, we, ch, div, eb, et, es, ee;
  } vec_t;
  vec_t v[$];

  tick_generator #(.CLK_HZ(20), .BASE_HZ(4), .NUM_CH(2), .DIV_W(4), .DEFAULT_DIV(3)) u_dut (
    .clk(clk), .reset_sync(reset_sync), .run(run), .clear(clear), .cfg_we(cfg_we),
    .cfg_ch(cfg_ch), .cfg_div(cfg_div), .cfg_err(cfg_err), .base_tick(base_tick),
    .tick(tick), .square(square));

  tick_generator #(.CLK_HZ(20), .BASE_HZ(4), .NUM_CH(3), .DIV_W(4), .DEFAULT_DIV(3)) u_dut3 (
    .clk(clk), .reset_sync(reset_sync), .run(run), .clear(clear), .cfg_we(cfg_we),
    .cfg_ch(ch3), .cfg_div(cfg_div), .cfg_err(err3), .base_tick(base3),
    .tick(tick3), .square(sq3));

  always #5 clk = ~clk;

  function automatic logic [5:0] pk(input int b, t, s, er);
    return 6'(er * 32 + s * 8 + t * 2 + b);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
    e++;
  endtask

  task automatic run_to(input int t);
    while (e < t) step();
  endtask

  task automatic chk(input string nm, input logic [5:0] want);
    logic [5:0] got;
    got = {cfg_err, square, tick, base_tick};
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s edge=%0d got=%b want=%b (err,sq[1:0],tick[1:0],base)", nm, e, got, want);
    end
  endtask

  task automatic chk3(input string nm, input logic want);
    total++;
    if (err3 !== want) begin
      bad++;
      $display("FAIL %s cfg_err(3ch) got=%b want=%b", nm, err3, want);
    end
  endtask

  task automatic do_reset();
    reset_sync = 1;
    run = 1;
    clear = 0;
    cfg_we = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_sync = 0;
    e = 0;
    chk("reset", 6'b0);
  endtask

  task automatic drive(input int r, c, w, ch, d);
    run = r != 0;
    clear = c != 0;
    cfg_we = w != 0;
    cfg_ch = 1'(ch);
    cfg_div = 4'(d);
    step();
    run = 1;
    clear = 0;
    cfg_we = 0;
  endtask

  initial begin
    // fields: rst, edge, run, clr, we, ch, div | base, tick, square, err
    v.push_back('{1, 1, 1,0,0,0,0, 0,0,0,0});
    v.push_back('{0, 4, 1,0,0,0,0, 0,0,0,0});
    v.push_back('{0, 5, 1,0,0,0,0, 1,0,0,0});
    v.push_back('{0, 6, 1,0,0,0,0, 0,0,0,0});
    v.push_back('{0,10, 1,0,0,0,0, 1,0,0,0});
    v.push_back('{0,15, 1,0,0,0,0, 1,0,0,0});
    v.push_back('{0,16, 1,0,0,0,0, 0,3,3,0});
    v.push_back('{0,17, 1,0,0,0,0, 0,0,3,0});
    v.push_back('{0,30, 1,0,0,0,0, 1,0,3,0});
    v.push_back('{0,31, 1,0,0,0,0, 0,3,0,0});
    v.push_back('{0,32, 1,0,0,0,0, 0,0,0,0});
    v.push_back('{1,20, 1,0,1,1,1, 1,0,3,0});
    v.push_back('{0,31, 1,0,0,0,0, 0,3,0,0});
    v.push_back('{0,35, 1,0,0,0,0, 1,0,0,0});
    v.push_back('{0,36, 1,0,0,0,0, 0,2,2,0});
    v.push_back('{0,41, 1,0,0,0,0, 0,2,0,0});
    v.push_back('{0,46, 1,0,0,0,0, 0,3,3,0});
    v.push_back('{1, 7, 1,0,1,0,0, 0,0,0,1});
    v.push_back('{0, 8, 1,0,0,0,0, 0,0,0,0});
    v.push_back('{0,12, 1,0,1,1,0, 0,0,0,1});
    v.push_back('{0,13, 1,0,0,0,0, 0,0,0,0});
    v.push_back('{0,16, 1,0,0,0,0, 0,3,3,0});
    v.push_back('{0,31, 1,0,0,0,0, 0,3,0,0});
    v.push_back('{1,15, 1,0,0,0,0, 1,0,0,0});
    v.push_back('{0,16, 0,0,0,0,0, 0,0,0,0});
    v.push_back('{0,21, 1,0,0,0,0, 1,0,0,0});
    v.push_back('{0,22, 1,0,0,0,0, 0,3,3,0});
    v.push_back('{1,16, 1,0,0,0,0, 0,3,3,0});
    v.push_back('{0,20, 1,1,0,0,0, 0,0,0,0});
    v.push_back('{0,25, 1,0,0,0,0, 1,0,0,0});
    v.push_back('{0,31, 1,0,0,0,0, 0,0,0,0});
    v.push_back('{0,36, 1,0,0,0,0, 0,3,3,0});
    v.push_back('{1,16, 1,0,1,0,1, 0,3,3,0});
    v.push_back('{0,20, 1,0,1,1,1, 1,0,3,0});
    v.push_back('{0,25, 1,0,1,1,2, 1,0,3,0});
    v.push_back('{0,31, 1,0,0,0,0, 0,3,0,0});
    v.push_back('{0,36, 1,0,0,0,0, 0,1,1,0});
    v.push_back('{0,41, 1,0,0,0,0, 0,3,2,0});
    v.push_back('{0,46, 1,0,0,0,0, 0,1,3,0});
    v.push_back('{0,51, 1,0,0,0,0, 0,3,0,0});

    do_reset();
    ch3 = 3; cfg_div = 5; cfg_we = 1; step(); cfg_we = 0;
    chk3("ch_out_of_range", 1'b1);
    step();
    chk3("err_one_cycle", 1'b0);
    ch3 = 2; cfg_div = 0; cfg_we = 1; step(); cfg_we = 0;
    chk3("div_zero", 1'b1);
    ch3 = 2; cfg_div = 1; cfg_we = 1; step(); cfg_we = 0;
    chk3("ch2_accepted", 1'b0);

    foreach (v[k]) begin
      if (v[k].rst != 0) do_reset();
      run_to(v[k].e - 1);
      drive(v[k].run, v[k].clr, v[k].we, v[k].ch, v[k].div);
      chk($sformatf("vec%0d", k), pk(v[k].eb, v[k].et, v[k].es, v[k].ee));
    end

    // seven-cycle freeze, then a second freeze while square is high
    do_reset();
    run_to(11);
    run = 0;
    for (int i = 0; i < 7; i++) begin
      step();
      chk("freeze", 6'b0);
    end
    run = 1;
    run_to(21); chk("frz_e21", 6'b0);
    step();     chk("frz_base22", pk(1,0,0,0));
    step();     chk("frz_tick23", pk(0,3,3,0));
    run_to(37); chk("frz_base37", pk(1,0,3,0));
    step();     chk("frz_tick38", pk(0,3,0,0));
    run_to(53); chk("frz_tick53", pk(0,3,3,0));
    run = 0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("freeze_sq_hold", pk(0,0,3,0));
    end
    run = 1;
    run_to(60); chk("frz_base60", pk(1,0,3,0));
    run_to(71); chk("frz_tick71", pk(0,3,0,0));

    // pending divisor is loaded by clear
    do_reset();
    run_to(2);  drive(1,0,1,0,2); chk("clr_wr", 6'b0);
    run_to(7);  drive(1,1,0,0,0); chk("clr_edge", 6'b0);
    run_to(13); chk("clr_base13", pk(1,0,0,0));
    run_to(19); chk("clr_ch0_19", pk(0,1,1,0));
    run_to(24); chk("clr_ch1_24", pk(0,2,3,0));
    run_to(29); chk("clr_ch0_29", pk(0,1,2,0));
    run_to(39); chk("clr_both_39", pk(0,3,1,0));

    // asynchronous reset discards a pending divisor
    do_reset();
    run_to(15); drive(1,0,1,0,2); chk("ar_wrap16", pk(0,3,3,0));
    run_to(20); chk("ar_pre", pk(1,0,3,0));
    #2 reset_sync = 1;
    #1 chk("async_reset", 6'b0);
    do_reset();
    run_to(16); chk("ar_tick16", pk(0,3,3,0));
    run_to(26); chk("ar_no26", pk(0,0,3,0));
    run_to(31); chk("ar_tick31", pk(0,3,0,0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
